// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the fetch/redirect control path: state encoding,
// default vectors and immediate sign extension.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

    // Sign-extend the low w bits of v to 32 bits (w in 1..32).
    function automatic logic [31:0] sext(input logic [31:0] v, input logic [5:0] w);
        logic [5:0] sh;
        sh = 6'd32 - w;
        return $signed(v << sh) >>> sh;
    endfunction

endpackage

// File: rtl/redirect_target_sel.sv
// Combinational target computation and EX-over-ID redirect priority.
module redirect_target_sel
    import core_ctrl_pkg::*;
(
    input  logic        stall,
    input  logic        id_jal,
    input  logic [31:0] id_pc,
    input  logic [20:0] id_imm21,
    input  logic        ex_jalr,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs1,
    input  logic [11:0] ex_imm12,
    input  logic [12:0] ex_imm13,
    output logic        sel_valid,
    output logic [31:0] sel_target,
    output logic        sel_is_ex,
    output logic        sel_is_jump,
    output logic [31:0] sel_link,
    output logic        sel_misaligned
);

    logic [31:0] jal_t, jalr_t, br_t;
    logic        ex_req;

    always_comb begin
        jal_t  = id_pc + sext({11'b0, id_imm21}, 6'd21);
        jalr_t = (ex_rs1 + sext({20'b0, ex_imm12}, 6'd12)) & ~32'h1;
        br_t   = ex_pc + sext({19'b0, ex_imm13}, 6'd13);
        ex_req = ex_jalr | ex_br_taken;

        // EX holds the older instruction and is never held off by stall.
        sel_valid      = ex_req | (id_jal & ~stall);
        sel_is_ex      = ex_req;
        sel_is_jump    = ex_jalr | (~ex_req & id_jal);
        sel_target     = ex_req ? (ex_jalr ? jalr_t : br_t) : jal_t;
        sel_link       = (ex_req ? ex_pc : id_pc) + 32'd4;
        sel_misaligned = sel_valid & sel_target[1];
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: BOOT/RUN/TRAP FSM, PC and link registers, redirect counter.
module pc_redirect_ctrl
    import core_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        id_jal,
    input  logic [31:0] id_pc,
    input  logic [20:0] id_imm21,
    input  logic        ex_jalr,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs1,
    input  logic [11:0] ex_imm12,
    input  logic [12:0] ex_imm13,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] link_addr,
    output logic        trap,
    output logic [15:0] redirect_cnt
);

    ctrl_state_e state_q, state_d;
    logic [31:0] pc_q, pc_d, link_q, link_d;
    logic [15:0] cnt_q, cnt_d;

    logic        sel_valid, sel_is_ex, sel_is_jump, sel_misaligned;
    logic [31:0] sel_target, sel_link;
    logic        acc;

    redirect_target_sel u_sel (
        .stall          (stall),
        .id_jal         (id_jal),
        .id_pc          (id_pc),
        .id_imm21       (id_imm21),
        .ex_jalr        (ex_jalr),
        .ex_br_taken    (ex_br_taken),
        .ex_pc          (ex_pc),
        .ex_rs1         (ex_rs1),
        .ex_imm12       (ex_imm12),
        .ex_imm13       (ex_imm13),
        .sel_valid      (sel_valid),
        .sel_target     (sel_target),
        .sel_is_ex      (sel_is_ex),
        .sel_is_jump    (sel_is_jump),
        .sel_link       (sel_link),
        .sel_misaligned (sel_misaligned)
    );

    // Requests are only honoured in RUN; in BOOT/TRAP upstream is empty or flushed.
    assign acc = (state_q == ST_RUN) & sel_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            link_q  <= 32'h0;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        link_d  = link_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (acc && sel_misaligned) begin
                    // Exception: the faulting jump does not write its link.
                    state_d = ST_TRAP;
                end else if (acc) begin
                    pc_d  = sel_target;
                    cnt_d = cnt_q + 16'd1;
                    if (sel_is_jump) link_d = sel_link;
                end else if (!stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_TRAP: begin
                pc_d    = TRAP_VEC;
                state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state_q == ST_RUN) & (acc | ~stall);
        flush_if_id = acc;
        flush_id_ex = acc & sel_is_ex;
        trap        = (state_q == ST_TRAP);
    end

    assign pc           = pc_q;
    assign link_addr    = link_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequences the fetch PC of the pipelined RV32I core.
- Arbitrates control-flow redirects from two sources:
  - JAL resolved in decode (ID).
  - JALR and taken branches resolved in execute (EX).
- Generates the pipeline flush strobes and link addresses, and traps misaligned targets.
- Sits between the hazard unit, the jump/branch target logic and the instruction-fetch stage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TRAP_VEC, 32'h0000_0100, fetch address taken on a misaligned redirect target.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- id_jal  in  1  JAL valid in ID.
- id_pc  in  32  PC of the ID instruction.
- id_imm21  in  21  JAL immediate, byte offset, signed.
- ex_jalr  in  1  JALR valid in EX.
- ex_br_taken  in  1  conditional branch resolved taken in EX.
- ex_pc  in  32  PC of the EX instruction.
- ex_rs1  in  32  rs1 operand value for JALR.
- ex_imm12  in  12  JALR immediate, signed.
- ex_imm13  in  13  branch immediate, byte offset, signed.
- pc  out  32  current fetch address.
- fetch_valid  out  1  pc is a valid fetch this cycle.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  squash the ID/EX register.
- link_addr  out  32  return address (PC+4) of the accepted jump.
- trap  out  1  one-cycle misaligned-target exception pulse.
- redirect_cnt  out  16  count of accepted redirects; wraps.

Behaviour:
- Reset: applied asynchronously while rst_n=0.
  - pc=RESET_PC, state=BOOT.
  - fetch_valid=0, trap=0, redirect_cnt=0.
  - flush_if_id=0, flush_id_ex=0, link_addr=0.
- Target arithmetic: all additions mod 2^32; immediates sign-extended to 32 bits.
  - JAL target = id_pc + sext(id_imm21).
  - JALR target = (ex_rs1 + sext(ex_imm12)) & ~32'h1.
  - Branch target = ex_pc + sext(ex_imm13).
- Misaligned: the selected target has bit[1]=1 (no compressed support).
- Priority, evaluated combinationally each cycle in RUN:
  - EX request (ex_jalr or ex_br_taken) beats id_jal, because EX holds the older instruction.
  - If ex_jalr and ex_br_taken are both 1, ex_jalr wins; this is a protocol error, flagged by a bench assertion.
  - An EX request is accepted regardless of stall.
  - id_jal is accepted only when stall=0 and there is no EX request; a stalled JAL re-presents later.
- Flush outputs are combinational in the cycle a redirect is accepted.
  - EX redirect: flush_if_id=1, flush_id_ex=1.
  - ID JAL: flush_if_id=1 only.
  - Misaligned-target request: same flush pattern as the equivalent aligned redirect.
- link_addr is registered: it equals (source PC)+4 from the cycle after acceptance, then holds until the next accepted jump. A branch does not update it.
- redirect_cnt increments by 1 on each accepted aligned redirect; 16'hFFFF wraps to 0. Traps are not counted.
- State machine:
  - BOOT: fetch_valid=0 for exactly one cycle after reset release, then RUN with pc=RESET_PC.
  - RUN: fetch_valid=1, except when stall=1 with no accepted redirect, where fetch_valid=0 and pc holds.
    - Accepted aligned redirect: pc <= target next edge.
    - Accepted misaligned redirect: go to TRAP.
    - Neither: pc <= pc+4 if stall=0, else hold.
  - TRAP: for one cycle, trap=1 and fetch_valid=0; pc <= TRAP_VEC. Next state RUN.
    - All requests arriving in TRAP are ignored; upstream is already flushed.
- Boundaries:
  - pc+4 wraps from 32'hFFFF_FFFC to 32'h0.
  - Redirect to the current pc is legal and counts.
  - Reset asserted mid-TRAP or mid-redirect returns to BOOT immediately, with the reset values above.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - the state encoding (BOOT=2'd0, RUN=2'd1, TRAP=2'd2);
  - the default values of RESET_PC and TRAP_VEC;
  - a sign-extension helper function.
- One sub-module, redirect_target_sel:
  - purely combinational;
  - computes the three targets and applies the priority;
  - outputs sel_valid, sel_target, sel_is_ex, sel_link, sel_misaligned.
- The parent module keeps the FSM, PC register, link register and counter.

Test Plan:
- Reset release, no requests -> fetch_valid=0 for 1 cycle; then pc = 0x0, 0x4, 0x8 on successive cycles.
- pc=0x10, id_jal with id_pc=0x0C, imm21=+0x20 -> flush_if_id=1, flush_id_ex=0; next pc=0x2C, link_addr=0x10, redirect_cnt=1.
- Same cycle: id_jal (target 0x40) plus ex_br_taken (ex_pc=0x08, imm13=-8) with stall=1 -> both flushes=1; next pc=0x00; the JAL is ignored.
- ex_jalr with rs1=0x1003, imm12=0x001 -> target 0x1004 (bit0 cleared), link_addr=ex_pc+4. Then rs1=0x1001, imm12=1 -> target 0x1002 -> trap=1 for 1 cycle, fetch_valid=0; next pc=0x100; redirect_cnt unchanged.
- pc=0x20, stall=1 for 3 cycles -> pc held at 0x20, fetch_valid=0; then stall=0 -> next pc=0x24.
- rst_n pulsed low mid-TRAP -> all outputs take reset values asynchronously; BOOT sequence restarts. Separately, 65536 redirects -> redirect_cnt wraps to 0.
